// File: rtl/cs161_ctrl_pkg.sv
// Shared encodings for the CS161 multi-cycle control unit: states, opcodes,
// funct codes, ALU codes, mux selects and the per-state Moore output table.
package cs161_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // R_EX leaves alu_op at 0 here; the top muxes in the funct decode.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = ASB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = ASB_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ASB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
                c.done      = 1'b1;
            end
            S_R_EX: c.alu_src_a = 1'b1;
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.done      = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.branch    = 1'b1;
                c.pc_source = PCS_ALUOUT;
                c.done      = 1'b1;
            end
            S_JMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
                c.done      = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cs161_alu_decoder.sv
// R-type funct to ALU code decode; the legal flag feeds the DECODE illegal check.
module cs161_alu_decoder
    import cs161_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic       legal
);

    always_comb begin
        alu_code = ALU_AND;
        legal    = 1'b1;
        case (funct)
            FN_ADD:  alu_code = ALU_ADD;
            FN_SUB:  alu_code = ALU_SUB;
            FN_AND:  alu_code = ALU_AND;
            FN_OR:   alu_code = ALU_OR;
            FN_SLT:  alu_code = ALU_SLT;
            FN_NOR:  alu_code = ALU_NOR;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/cs161_multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM. Moore outputs are registered from the
// next state; only R_EX alu_op and the DECODE illegal pulse look at IR fields.
module cs161_multicycle_ctrl
    import cs161_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] instr_op,
    input  logic [5:0] funct,
    output logic       pc_write,
    output logic       branch,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state_out,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e     state_q;
    state_e     state_nxt;
    state_e     state_go;
    logic       run_q;
    ctrl_t      ctrl_q;
    logic [3:0] dec_code;
    logic       fn_legal;
    logic       illegal;

    cs161_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_code (dec_code),
        .legal    (fn_legal)
    );

    assign illegal = !op_supported(instr_op) || ((instr_op == OP_RTYPE) && !fn_legal);

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (!illegal) begin
                    case (instr_op)
                        OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                        OP_RTYPE:     state_nxt = S_R_EX;
                        OP_BEQ:       state_nxt = S_BEQ;
                        OP_J:         state_nxt = S_JMP;
                        OP_ADDI:      state_nxt = S_ADDI_EX;
                        default:      state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: state_nxt = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_nxt = S_MEM_WB;
            S_R_EX:     state_nxt = S_R_WB;
            S_ADDI_EX:  state_nxt = S_ADDI_WB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // The first edge after reset release only arms FETCH; stepping starts after it.
    assign state_go = run_q ? state_nxt : S_FETCH;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_FETCH;
            run_q            <= 1'b0;
            ctrl_q           <= '0;
            ctrl_q.alu_src_b <= ASB_FOUR;
            ctrl_q.alu_op    <= ALU_ADD;
        end else begin
            run_q  <= 1'b1;
            state_q <= state_go;
            ctrl_q <= state_ctrl(state_go);
        end
    end

    assign pc_write   = ctrl_q.pc_write;
    assign branch     = ctrl_q.branch;
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_dst    = ctrl_q.reg_dst;
    assign reg_write  = ctrl_q.reg_write;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = (state_q == S_R_EX) ? dec_code : ctrl_q.alu_op;
    assign pc_source  = ctrl_q.pc_source;
    assign state_out  = state_q;
    assign illegal_op = (state_q == S_DECODE) && illegal;
    assign instr_done = ctrl_q.done || illegal_op;

endmodule

// File: tb/tb_cs161_multicycle_ctrl.sv
// Directed bench for cs161_multicycle_ctrl: per-cycle state and output-vector checks.
module tb_cs161_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] instr_op;
    logic [5:0] funct;
    logic       pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op, state_out;
    logic       instr_done, illegal_op;
    logic [19:0] obs;

    int checks = 0;
    int errors = 0;

    // {pc_write,branch,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,
    //  reg_write,alu_src_a,alu_src_b[2],alu_op[4],pc_source[2],instr_done,illegal_op}
    localparam logic [19:0] V_RESET   = 20'b0_0_0_0_0_0_0_0_0_0_01_0010_00_0_0;
    localparam logic [19:0] V_FETCH   = 20'b1_0_0_1_0_1_0_0_0_0_01_0010_00_0_0;
    localparam logic [19:0] V_DECODE  = 20'b0_0_0_0_0_0_0_0_0_0_11_0010_00_0_0;
    localparam logic [19:0] V_DEC_ILL = 20'b0_0_0_0_0_0_0_0_0_0_11_0010_00_1_1;
    localparam logic [19:0] V_ADDR    = 20'b0_0_0_0_0_0_0_0_0_1_10_0010_00_0_0;
    localparam logic [19:0] V_MEM_RD  = 20'b0_0_1_1_0_0_0_0_0_0_00_0000_00_0_0;
    localparam logic [19:0] V_MEM_WB  = 20'b0_0_0_0_0_0_1_0_1_0_00_0000_00_1_0;
    localparam logic [19:0] V_MEM_WR  = 20'b0_0_1_0_1_0_0_0_0_0_00_0000_00_1_0;
    localparam logic [19:0] V_R_WB    = 20'b0_0_0_0_0_0_0_1_1_0_00_0000_00_1_0;
    localparam logic [19:0] V_BEQ     = 20'b0_1_0_0_0_0_0_0_0_1_00_0110_01_1_0;
    localparam logic [19:0] V_JMP     = 20'b1_0_0_0_0_0_0_0_0_0_00_0000_10_1_0;
    localparam logic [19:0] V_ADDI_WB = 20'b0_0_0_0_0_0_0_0_1_0_00_0000_00_1_0;

    assign obs = {pc_write, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  instr_done, illegal_op};

    cs161_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .instr_op   (instr_op),
        .funct      (funct),
        .pc_write   (pc_write),
        .branch     (branch),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state_out  (state_out),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [3:0] est, input logic [19:0] ev);
        checks++;
        assert (state_out === est) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state_out, est);
        end
        checks++;
        assert (obs === ev) else begin
            errors++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs, ev);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] est, input logic [19:0] ev);
        @(negedge clk);
        chk(tag, est, ev);
    endtask

    initial begin
        logic [5:0] fns  [6];
        logic [3:0] codes[6];
        fns   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

        rst = 1'b0; instr_op = 6'b0; funct = 6'b0;
        repeat (3) @(negedge clk);
        chk("reset", 4'd0, V_RESET);
        rst = 1'b1;
        cyc("release_fetch", 4'd0, V_FETCH);

        // lw
        instr_op = 6'b100011; funct = 6'b000000;
        cyc("lw_dec", 4'd1, V_DECODE);
        cyc("lw_addr", 4'd2, V_ADDR);
        cyc("lw_rd", 4'd3, V_MEM_RD);
        cyc("lw_wb", 4'd4, V_MEM_WB);
        cyc("lw_next", 4'd0, V_FETCH);

        // sw
        instr_op = 6'b101011;
        cyc("sw_dec", 4'd1, V_DECODE);
        cyc("sw_addr", 4'd2, V_ADDR);
        cyc("sw_wr", 4'd5, V_MEM_WR);
        cyc("sw_next", 4'd0, V_FETCH);

        // sw interrupted by reset in MEM_ADDR: async return to FETCH, no store
        cyc("swr_dec", 4'd1, V_DECODE);
        cyc("swr_addr", 4'd2, V_ADDR);
        rst = 1'b0;
        #1;
        chk("swr_async", 4'd0, V_RESET);
        cyc("swr_hold1", 4'd0, V_RESET);
        cyc("swr_hold2", 4'd0, V_RESET);
        cyc("swr_hold3", 4'd0, V_RESET);
        rst = 1'b1;
        cyc("swr_fetch", 4'd0, V_FETCH);

        // R-type, every supported funct
        instr_op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = fns[i];
            cyc("r_dec", 4'd1, V_DECODE);
            cyc("r_ex", 4'd6, {10'b0000000001, 2'b00, codes[i], 2'b00, 2'b00});
            cyc("r_wb", 4'd7, V_R_WB);
            cyc("r_next", 4'd0, V_FETCH);
        end

        // addi
        instr_op = 6'b001000; funct = 6'b111111;
        cyc("addi_dec", 4'd1, V_DECODE);
        cyc("addi_ex", 4'd10, V_ADDR);
        cyc("addi_wb", 4'd11, V_ADDI_WB);
        cyc("addi_next", 4'd0, V_FETCH);

        // beq
        instr_op = 6'b000100; funct = 6'b000000;
        cyc("beq_dec", 4'd1, V_DECODE);
        cyc("beq_ex", 4'd8, V_BEQ);
        cyc("beq_next", 4'd0, V_FETCH);

        // j
        instr_op = 6'b000010;
        cyc("j_dec", 4'd1, V_DECODE);
        cyc("j_ex", 4'd9, V_JMP);
        cyc("j_next", 4'd0, V_FETCH);

        // illegal opcode
        instr_op = 6'b111111; funct = 6'b100000;
        cyc("ill_op_dec", 4'd1, V_DEC_ILL);
        cyc("ill_op_next", 4'd0, V_FETCH);

        // R-type with unsupported funct
        instr_op = 6'b000000; funct = 6'b000000;
        cyc("ill_fn_dec", 4'd1, V_DEC_ILL);
        cyc("ill_fn_next", 4'd0, V_FETCH);

        // back-to-back legal op after illegal ones
        instr_op = 6'b100011;
        cyc("lw2_dec", 4'd1, V_DECODE);
        cyc("lw2_addr", 4'd2, V_ADDR);
        cyc("lw2_rd", 4'd3, V_MEM_RD);
        cyc("lw2_wb", 4'd4, V_MEM_WB);
        cyc("lw2_next", 4'd0, V_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs161_multicycle_ctrl.md
# cs161_multicycle_ctrl

Multi-cycle control unit for the CS161 MIPS-subset CPU. It decodes the 6-bit opcode and function fields returned by the multi-cycle datapath and steps a Moore state machine through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath's control inputs. The unit sits beside the datapath and is the only source of its write enables and mux selects.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `instr_op` in 6: opcode from the datapath instruction register. Valid from DECODE onward.
- `funct` in 6: function field from the instruction register. Valid from DECODE onward.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: conditional PC load. The datapath ANDs it with ALU zero.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: register write-data select. 0 = ALUOut, 1 = MDR.
- `reg_dst` out 1: destination register select. 0 = rt, 1 = rd.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op` out 4: ALU control code, driven directly to the ALU.
- `pc_source` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state_out` out 4: current state encoding (debug).
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode or funct is decoded.

## Operation
- Supported opcodes:
  - R-type `000000`
  - lw `100011`
  - sw `101011`
  - beq `000100`
  - j `000010`
  - addi `001000`
- Supported R-type funct values:
  - add `100000` → ADD
  - sub `100010` → SUB
  - and `100100` → AND
  - or `100101` → OR
  - slt `101010` → SLT
  - nor `100111` → NOR
- ALU codes: AND `0000`, OR `0001`, ADD `0010`, SUB `0110`, SLT `0111`, NOR `1100`.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BEQ 8, JMP 9, ADDI_EX 10, ADDI_WB 11. Encodings 12–15 are unreachable and return to FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEM_ADDR (lw/sw), R_EX (legal R-type), BEQ, JMP, ADDI_EX, or FETCH (illegal).
  - MEM_ADDR → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD → MEM_WB; R_EX → R_WB; ADDI_EX → ADDI_WB.
  - MEM_WB, MEM_WR, R_WB, BEQ, JMP, ADDI_WB → FETCH.
- Outputs per state (Moore; any signal not listed is 0, including `alu_op` = `0000`):
  - FETCH: `mem_read`, `ir_write`, `pc_write`, `alu_src_b` = 01, `alu_op` = ADD.
  - DECODE: `alu_src_b` = 11, `alu_op` = ADD (branch target into ALUOut).
  - MEM_ADDR and ADDI_EX: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = ADD.
  - MEM_RD: `mem_read`, `i_or_d`.
  - MEM_WB: `reg_write`, `mem_to_reg`.
  - MEM_WR: `mem_write`, `i_or_d`.
  - R_EX: `alu_src_a` = 1, `alu_op` = funct decode.
  - R_WB: `reg_write`, `reg_dst`.
  - BEQ: `alu_src_a` = 1, `alu_op` = SUB, `branch`, `pc_source` = 01.
  - JMP: `pc_write`, `pc_source` = 10.
  - ADDI_WB: `reg_write`.
- `funct` is checked in DECODE for legality and re-read in R_EX. The IR is stable between fetches, so both reads see the same value.
- `instr_done` is asserted in MEM_WB, MEM_WR, R_WB, BEQ, JMP and ADDI_WB, and in DECODE when the instruction is illegal.
- `illegal_op` is asserted in DECODE only, for an illegal opcode or an R-type with unsupported funct.

## Timing
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Outputs decode from the registered state only. `alu_op` in R_EX additionally depends on `funct`. There is no combinational path from `instr_op` to any write enable.
- While `rst` is low: state = FETCH and `state_out` = 0.
  - `pc_write`, `branch`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `instr_done` and `illegal_op` are forced 0.
  - All other outputs hold their FETCH values.
- FETCH behaviour starts on the first rising edge after `rst` deasserts.
- If `rst` is asserted mid-instruction, the state goes to FETCH immediately and no write strobe fires afterwards. A partially executed sw never issues `mem_write`.

## Structure
- Package `cs161_ctrl_pkg` holds:
  - the state encodings,
  - the opcode and funct constants,
  - the 4-bit ALU codes,
  - the `alu_src_b` and `pc_source` select constants.
- Sub-module `cs161_alu_decoder`: combinational funct → {alu code, legal flag}. It serves both the DECODE legality check and R_EX.
- The top level contains the state register, the next-state logic and the output decode.

## Test plan
- Reset: hold `rst` low for 3 cycles mid-stream, then release → `state_out` = 0, all strobes 0; FETCH outputs (`ir_write` = 1, `alu_op` = `0010`) appear in the cycle after release.
- lw: `instr_op` = `100011` → states 0, 1, 2, 3, 4; `reg_write` = 1 with `mem_to_reg` = 1 in state 4 only; `instr_done` once, at cycle 5.
- sw, then sw with reset: sw `101011` → states 0, 1, 2, 5 with `mem_write` for exactly one cycle. Repeat, pulling `rst` low while in state 2 → no `mem_write` pulse.
- R-type: `instr_op` = 0 with each of the 6 funct values → R_EX `alu_op` equals the mapped code (e.g. sub → `0110`); R_WB asserts `reg_dst` = 1 and `reg_write` = 1.
- beq and j: beq `000100` → BEQ with `branch` = 1, `pc_source` = 01, `alu_op` = `0110`, back to FETCH on the next edge. j `000010` → JMP with `pc_write` = 1 and `pc_source` = 10.
- Illegal: opcode `111111`, and R-type with funct `000000` → `illegal_op` and `instr_done` pulse in DECODE, next state FETCH, no write strobe asserted.
